// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: register-side and pin-side signals of the SPI transfer
// controller, bundled for connection to spi_xfer_ctrl.
//   master modport: the register file / bench driving config, strobes, miso.
//   slave modport : the controller consuming those and producing sck, mosi,
//                   ss_n, rx_data and the spif/sptef/busy status bits.
interface spi_xfer_ctrl_if;
  logic       spe;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       dr_wr;
  logic [7:0] dr_wdata;
  logic       dr_rd;
  logic       sr_rd;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       ss_n;
  logic [7:0] rx_data;
  logic       spif;
  logic       sptef;
  logic       busy;

  modport master (
    output spe, cpol, cpha, lsbfe, sppr, spr, dr_wr, dr_wdata, dr_rd, sr_rd, miso,
    input  sck, mosi, ss_n, rx_data, spif, sptef, busy
  );

  modport slave (
    input  spe, cpol, cpha, lsbfe, sppr, spr, dr_wr, dr_wdata, dr_rd, sr_rd, miso,
    output sck, mosi, ss_n, rx_data, spif, sptef, busy
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: master-mode SPI byte transfer controller. One data-register
// write queues a byte in the tx buffer; the FSM shifts it out on mosi while
// sampling miso, then reports the received byte through rx_data/spif.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : spi_xfer_ctrl_if.slave -- config (spe/cpol/cpha/lsbfe/sppr/spr),
//          register strobes (dr_wr/dr_wdata/dr_rd/sr_rd), miso in;
//          sck/mosi/ss_n, rx_data, spif/sptef/busy out (all registered).
module spi_xfer_ctrl (
  input  logic           clk,
  input  logic           rst,
  spi_xfer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TRAIL = 2'd2} state_e;

  state_e      state_q;
  logic        sck_q, mosi_q, ss_n_q, spif_q, sptef_q, busy_q, arm_q;
  logic        cpol_q, cpha_q, lsbfe_q;
  logic [7:0]  tx_buf_q, tx_sh_q, rx_sh_q, rx_data_q;
  logic [10:0] half_q, cnt_q;
  logic [4:0]  edge_q;

  logic [10:0] half_d;
  logic [4:0]  edge_d;
  logic        tick;
  logic        clr_req;

  always_comb begin
    // Half period H = (sppr+1) * 2^spr, i.e. half of the baud divisor.
    half_d  = (11'(bus.sppr) + 11'd1) << bus.spr;
    tick    = (cnt_q == half_q - 11'd1);
    edge_d  = edge_q + 5'd1;
    clr_req = bus.dr_rd & arm_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      spif_q    <= 1'b0;
      sptef_q   <= 1'b1;
      busy_q    <= 1'b0;
      arm_q     <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      tx_buf_q  <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      half_q    <= 11'd1;
      cnt_q     <= '0;
      edge_q    <= '0;
    end else begin
      // SPIF clear is a two-step sequence: status read arms, data read clears.
      if (bus.sr_rd && spif_q) arm_q <= 1'b1;
      if (clr_req) begin
        spif_q <= 1'b0;
        arm_q  <= 1'b0;
      end

      if (!bus.spe) begin
        state_q <= IDLE;
        sck_q   <= bus.cpol;
        ss_n_q  <= 1'b1;
        busy_q  <= 1'b0;
        sptef_q <= 1'b1;
      end else begin
        if (bus.dr_wr && sptef_q) begin
          tx_buf_q <= bus.dr_wdata;
          sptef_q  <= 1'b0;
        end

        unique case (state_q)
          IDLE: begin
            sck_q  <= bus.cpol;
            ss_n_q <= 1'b1;
            if (!sptef_q) begin
              cpol_q  <= bus.cpol;
              cpha_q  <= bus.cpha;
              lsbfe_q <= bus.lsbfe;
              half_q  <= half_d;
              sptef_q <= 1'b1;
              ss_n_q  <= 1'b0;
              busy_q  <= 1'b1;
              edge_q  <= '0;
              cnt_q   <= '0;
              rx_sh_q <= '0;
              state_q <= XFER;
              // cpha=0 presents the first bit before any sck edge.
              if (bus.cpha) begin
                tx_sh_q <= tx_buf_q;
              end else begin
                mosi_q  <= bus.lsbfe ? tx_buf_q[0] : tx_buf_q[7];
                tx_sh_q <= bus.lsbfe ? {1'b0, tx_buf_q[7:1]} : {tx_buf_q[6:0], 1'b0};
              end
            end
          end

          XFER: begin
            if (tick) begin
              cnt_q  <= '0;
              sck_q  <= ~sck_q;
              edge_q <= edge_d;
              // Sample edges are odd for cpha=0 and even for cpha=1.
              if (edge_d[0] != cpha_q) begin
                rx_sh_q <= lsbfe_q ? {bus.miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], bus.miso};
              end else if (cpha_q || edge_d != 5'd16) begin
                mosi_q  <= lsbfe_q ? tx_sh_q[0] : tx_sh_q[7];
                tx_sh_q <= lsbfe_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
              end
              if (edge_d == 5'd16) state_q <= TRAIL;
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end

          TRAIL: begin
            if (tick) begin
              cnt_q   <= '0;
              sck_q   <= cpol_q;
              ss_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
              // A clear landing on the completion cycle loses to the new byte.
              if (!spif_q || clr_req) begin
                rx_data_q <= rx_sh_q;
                spif_q    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;
  assign bus.rx_data = rx_data_q;
  assign bus.spif    = spif_q;
  assign bus.sptef   = sptef_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: table of per-mode transfers plus directed
// sequences for flag clearing, overrun, double buffering, abort and reset.
module tb_spi_xfer_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if bus ();
  spi_xfer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic [7:0] wdata;
    logic [7:0] sbyte;
    logic       loop;
    int         exp_h;
    int         exp_lat;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  int n_chk  = 0;
  int n_pass = 0;
  int pcnt   = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  // Slave model / line monitor state
  logic       cfg_cpha = 1'b0;
  logic       cfg_lsb  = 1'b0;
  logic       loop     = 1'b0;
  logic [7:0] sbyte    = 8'h00;
  logic [7:0] mon      = 8'h00;
  logic       s_miso   = 1'b0;
  logic       prev_ss  = 1'b1;
  logic       prev_sck = 1'b0;
  int         ntog     = 0;
  int         load_t   = 0;
  int         rise_t   = 0;
  int         ss_gap   = 0;
  int         edge_t[17];

  assign bus.miso = loop ? bus.mosi : s_miso;

  function automatic logic bit_of(input logic [7:0] b, input int j, input logic lsb);
    int idx;
    idx = lsb ? j : 7 - j;
    return b[idx[2:0]];
  endfunction

  always @(negedge clk) begin : line_mon
    int k;
    int j;
    int idx;
    if (prev_ss && !bus.ss_n) begin
      load_t = pcnt;
      ss_gap = pcnt - rise_t;
      ntog   = 0;
      mon    = 8'h00;
      if (!cfg_cpha) s_miso = bit_of(sbyte, 0, cfg_lsb);
    end else if (!bus.ss_n && (bus.sck != prev_sck)) begin
      k    = ntog + 1;
      ntog = k;
      if (k <= 16) edge_t[k] = pcnt;
      if (k[0] != cfg_cpha) begin
        j = cfg_cpha ? k / 2 - 1 : (k - 1) / 2;
        if (j >= 0 && j < 8) begin
          idx = cfg_lsb ? j : 7 - j;
          mon[idx[2:0]] = bus.mosi;
        end
      end else begin
        j = cfg_cpha ? (k - 1) / 2 : k / 2;
        if (j < 8) s_miso = bit_of(sbyte, j, cfg_lsb);
      end
    end
    if (!prev_ss && bus.ss_n) rise_t = pcnt;
    prev_ss  = bus.ss_n;
    prev_sck = bus.sck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.dr_wdata = d;
    bus.dr_wr    = 1'b1;
    tick1();
    bus.dr_wr    = 1'b0;
  endtask

  task automatic pulse_sr();
    bus.sr_rd = 1'b1;
    tick1();
    bus.sr_rd = 1'b0;
  endtask

  task automatic pulse_dr();
    bus.dr_rd = 1'b1;
    tick1();
    bus.dr_rd = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n = 0;
    while (bus.busy !== lvl && n < 5000) begin
      tick1();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 5000), 32'd1);
  endtask

  task automatic set_cfg(input vec_t v);
    bus.cpol  = v.cpol;
    bus.cpha  = v.cpha;
    bus.lsbfe = v.lsbfe;
    bus.sppr  = v.sppr;
    bus.spr   = v.spr;
    cfg_cpha  = v.cpha;
    cfg_lsb   = v.lsbfe;
    sbyte     = v.sbyte;
    loop      = v.loop;
  endtask

  task automatic clear_spif(input string name);
    pulse_sr();
    pulse_dr();
    check(name, bus.spif, 1'b0);
  endtask

  task automatic do_xfer(input vec_t v, input int i);
    int e0;
    int n;
    int bad;
    set_cfg(v);
    tick1();
    tick1();
    check($sformatf("v%0d_sck_idle", i), bus.sck, v.cpol);
    wr(v.wdata);
    e0 = pcnt;
    check($sformatf("v%0d_sptef_after_wr", i), bus.sptef, 1'b0);
    tick1();
    check($sformatf("v%0d_load_sptef_busy_ssn", i), {bus.sptef, bus.busy, bus.ss_n}, 3'b110);
    n = 0;
    while (bus.spif !== 1'b1 && n < 5000) begin
      tick1();
      n++;
    end
    check($sformatf("v%0d_spif_latency", i), pcnt - e0, v.exp_lat);
    check($sformatf("v%0d_rx_data", i), bus.rx_data, v.exp_rx);
    check($sformatf("v%0d_mosi_bits", i), mon, v.wdata);
    check($sformatf("v%0d_sck_toggles", i), ntog, 16);
    check($sformatf("v%0d_load_delay", i), load_t - e0, 1);
    check($sformatf("v%0d_first_edge", i), edge_t[1] - load_t, v.exp_h);
    bad = 0;
    for (int k = 2; k <= 16; k++)
      if (edge_t[k] - edge_t[k-1] != v.exp_h) bad++;
    check($sformatf("v%0d_edge_spacing_bad", i), bad, 0);
    check($sformatf("v%0d_end_busy_ssn", i), {bus.busy, bus.ss_n}, 2'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hA5, 8'h3C, 1'b0, 1, 18, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 8'h81, 8'h00, 1'b1, 4, 69, 8'h81};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 8'h5A, 8'hC3, 1'b0, 3, 52, 8'hC3};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 3'd0, 3'd1, 8'h96, 8'h0F, 1'b0, 2, 35, 8'h0F};

    rst          = 1'b0;
    bus.spe      = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.lsbfe    = 1'b0;
    bus.sppr     = 3'd0;
    bus.spr      = 3'd0;
    bus.dr_wr    = 1'b0;
    bus.dr_wdata = 8'h00;
    bus.dr_rd    = 1'b0;
    bus.sr_rd    = 1'b0;
    repeat (3) tick1();
    check("rst_sck", bus.sck, 1'b0);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_ss_n", bus.ss_n, 1'b1);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_spif", bus.spif, 1'b0);
    check("rst_sptef", bus.sptef, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    tick1();

    // Writes with the block disabled are dropped.
    wr(8'h77);
    check("wr_spe0_ignored", bus.sptef, 1'b1);
    bus.spe = 1'b1;
    tick1();

    for (int i = 0; i < 4; i++) begin
      do_xfer(vecs[i], i);
      clear_spif($sformatf("v%0d_spif_clear", i));
    end

    // Unarmed dr_rd does not clear; overrun keeps the first byte.
    set_cfg(vecs[0]);
    sbyte = 8'h55;
    wr(8'h55);
    tick1();
    wait_busy(1'b0, "ovr_first");
    check("ovr_first_rx", bus.rx_data, 8'h55);
    pulse_dr();
    check("ovr_dr_noarm_spif", bus.spif, 1'b1);
    sbyte = 8'hAA;
    wr(8'hAA);
    tick1();
    wait_busy(1'b0, "ovr_second");
    check("ovr_rx_kept", bus.rx_data, 8'h55);
    check("ovr_spif_kept", bus.spif, 1'b1);
    clear_spif("ovr_clear");

    // Armed clear coinciding with completion: new byte lands, spif stays set.
    sbyte = 8'h66;
    wr(8'h66);
    tick1();
    wait_busy(1'b0, "sim_first");
    check("sim_first_rx", bus.rx_data, 8'h66);
    pulse_sr();
    sbyte = 8'h99;
    wr(8'h99);
    repeat (17) tick1();
    bus.dr_rd = 1'b1;
    tick1();
    bus.dr_rd = 1'b0;
    check("sim_rx_updated", bus.rx_data, 8'h99);
    check("sim_spif_set", bus.spif, 1'b1);
    check("sim_busy_done", bus.busy, 1'b0);
    pulse_dr();
    check("sim_arm_cleared", bus.spif, 1'b1);
    clear_spif("sim_clear");

    // Double buffering with a third write while the buffer is full.
    set_cfg(vecs[0]);
    bus.spr = 3'd1;
    sbyte   = 8'h11;
    wr(8'h11);
    tick1();
    wr(8'h22);
    check("dbl_second_accepted", bus.sptef, 1'b0);
    wr(8'h33);
    check("dbl_third_sptef", bus.sptef, 1'b0);
    wait_busy(1'b0, "dbl_first");
    check("dbl_first_rx", bus.rx_data, 8'h11);
    check("dbl_first_spif", bus.spif, 1'b1);
    wait_busy(1'b1, "dbl_second_start");
    wait_busy(1'b0, "dbl_second_end");
    check("dbl_second_mosi", mon, 8'h22);
    check("dbl_ss_gap", ss_gap, 1);
    check("dbl_overrun_rx", bus.rx_data, 8'h11);
    check("dbl_sptef_empty", bus.sptef, 1'b1);
    repeat (4) tick1();
    check("dbl_third_ignored", bus.busy, 1'b0);
    clear_spif("dbl_clear");

    // Abort after sck edge 5 with a byte still buffered.
    set_cfg(vecs[3]);
    tick1();
    tick1();
    wr(8'hC7);
    tick1();
    wr(8'h3E);
    n = 0;
    while (ntog < 5 && n < 200) begin
      tick1();
      n++;
    end
    check("abort_reach_edge5", 32'(n < 200), 32'd1);
    bus.spe = 1'b0;
    tick1();
    check("abort_sck", bus.sck, 1'b1);
    check("abort_ss_n", bus.ss_n, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sptef", bus.sptef, 1'b1);
    check("abort_spif", bus.spif, 1'b0);
    check("abort_rx_data", bus.rx_data, 8'h11);
    bus.spe = 1'b1;
    repeat (5) tick1();
    check("abort_buf_discarded", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a transfer.
    set_cfg(vecs[1]);
    tick1();
    tick1();
    wr(8'hFF);
    repeat (8) tick1();
    wr(8'hAB);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_sck", bus.sck, 1'b0);
    check("mid_rst_mosi", bus.mosi, 1'b0);
    check("mid_rst_ss_n", bus.ss_n, 1'b1);
    check("mid_rst_rx_data", bus.rx_data, 8'h00);
    check("mid_rst_spif", bus.spif, 1'b0);
    check("mid_rst_sptef", bus.sptef, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    tick1();
    rst = 1'b1;
    tick1();
    do_xfer(vecs[0], 4);
    clear_spif("post_rst_clear");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Master-mode SPI transfer controller that sequences one byte exchange per data-register write. It takes the configuration bits from the SPI control and baud registers and a one-byte transmit buffer, then generates SCK/SS_n/MOSI. It samples MISO and returns the received byte. It owns the SPIF and SPTEF status flags reported through the status register.

## Interface
Parameters:
- none. The data width is fixed at 8 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- spe  in  1  SPI enable (control register 1).
- cpol  in  1  clock polarity; idle level of sck.
- cpha  in  1  clock phase.
- lsbfe  in  1  1 = LSB first, 0 = MSB first.
- sppr  in  3  baud preselection.
- spr  in  3  baud selection.
- dr_wr  in  1  one-cycle data-register write strobe.
- dr_wdata  in  8  write data.
- dr_rd  in  1  one-cycle data-register read strobe.
- sr_rd  in  1  one-cycle status-register read strobe.
- miso  in  1  serial input.
- sck  out  1  serial clock.
- mosi  out  1  serial output.
- ss_n  out  1  slave select, active low.
- rx_data  out  8  last received byte.
- spif  out  1  transfer-complete flag.
- sptef  out  1  transmit buffer empty flag.
- busy  out  1  transfer in progress.

## Operation
- Reset values: sck=0, mosi=0, ss_n=1, rx_data=0x00, spif=0, sptef=1, busy=0, state IDLE, tx buffer 0x00.
- Divisor D = (sppr+1)·2^(spr+1), range 2..2048. Half-period H = D/2 clk cycles, using an 11-bit counter.
- Tx buffer load:
  - dr_wr while sptef=1 loads dr_wdata and clears sptef.
  - dr_wr while sptef=0 is ignored.
  - dr_wr while spe=0 is ignored.
- FSM states: IDLE, XFER, TRAIL.
  - IDLE:
    - sck=cpol, ss_n=1.
    - If spe=1 and sptef=0: latch cpol/cpha/lsbfe/H, load the shifter from the buffer, and set sptef=1.
    - Also set ss_n=0 and busy=1, clear the edge counter, and go to XFER.
  - XFER:
    - Every H clocks, sck toggles and the edge count increments (1..16).
    - cpha=0: the first bit is driven on mosi at load. Odd edges sample miso; even edges 2..14 shift out the next bit.
    - cpha=1: odd edges shift out the next bit (edge 1 drives the first bit). Even edges sample miso.
    - After edge 16, go to TRAIL.
  - TRAIL:
    - Wait H clocks, then set ss_n=1 and busy=0, and return to IDLE.
    - If spif=0: rx_data ← shifter and spif=1.
    - If spif=1 (overrun): rx_data is unchanged and the received byte is discarded.
- Bit order:
  - lsbfe=0: shift out bit 7 first; received bits enter at bit 0.
  - lsbfe=1: mirrored.
- Configuration changes during XFER/TRAIL have no effect until the next load.
- SPIF clear: sr_rd while spif=1 arms clear. The next dr_rd with arm set clears spif and arm. A dr_rd without arm has no effect on spif.
- Simultaneous completion and clearing dr_rd: the completion wins. spif stays 1, rx_data is updated, and arm is cleared.
- A buffered write during XFER is allowed. Back-to-back transfers start from IDLE on the clock after TRAIL ends.
- spe=0 in any state aborts within one clock:
  - go to IDLE with sck=cpol, ss_n=1, busy=0;
  - the buffer is discarded and sptef=1;
  - spif and rx_data are unchanged.
- An rst assertion mid-transfer forces the reset values immediately, asynchronously.

## Timing
- Edge E0 samples dr_wr → sptef=0 after E0.
- E1 (next edge, IDLE): load; ss_n=0, busy=1, sptef=1 after E1.
- SCK edge k occurs at E1+k·H, for k=1..16.
- spif=1, ss_n=1 and busy=0 after E1+17·H. The latency from dr_wr to spif is 17·H+1 clocks.
- Buffer written during XFER: the next ss_n falling edge is one clock after the previous rise. ss_n stays high for exactly 1 clock between bytes.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Mode 0 (cpol=0, cpha=0, lsbfe=0), sppr=0, spr=0 (H=1), write 0xA5, miso driven with 0x3C MSB-first → mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; spif rises 18 clocks after dr_wr; sptef returns to 1 one clock after the load.
- Mode 3 (cpol=1, cpha=1, lsbfe=1), sppr=1, spr=1 (D=8, H=4), write 0x81, loopback miso=mosi → sck idles high; 16 toggles spaced 4 clocks apart; rx_data=0x81; spif at 69 clocks.
- Flag clear and overrun:
  - After a completed 0x55 transfer, dr_rd without a prior sr_rd → spif stays 1.
  - A second transfer of 0xAA completes → rx_data remains 0x55.
  - Then sr_rd followed by dr_rd → spif=0.
- Double buffering: write 0x11, then write 0x22 during XFER, then a third write while sptef=0 → third write ignored; two transfers complete; ss_n high for exactly 1 clock between them.
- Abort: spe deasserted at SCK edge 5 of a transfer → within 1 clock sck=cpol, ss_n=1, busy=0, sptef=1; spif and rx_data unchanged.
- Reset: rst low mid-XFER → all outputs take their reset values immediately; a transfer after rst deasserts runs normally.
